// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared parameters and types for the 8-way round-robin arbiter
package arb_pkg;

  localparam int N        = 8;
  localparam int IDXW     = 3;
  localparam int MAX_HOLD = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef logic [N-1:0]    req_vec_t;
  typedef logic [IDXW-1:0] idx_t;

endpackage

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - rotating priority find with 8:3 encode
// Candidates are req with mask removed; the first set bit at or above ptr wins, wrapping 7 -> 0.
module rr_pick8
  import arb_pkg::*;
(
  input  req_vec_t req,
  input  req_vec_t mask,
  input  idx_t     ptr,
  output logic     found,
  output req_vec_t winner,
  output idx_t     winner_idx
);

  req_vec_t           cand;
  logic [2*N-1:0]     dbl;
  req_vec_t           rot;
  idx_t               off;

  always_comb begin
    cand  = req & ~mask;
    // rot[k] holds the candidate k places above ptr
    dbl   = {cand, cand};
    rot   = dbl[ptr +: N];
    found = 1'b0;
    off   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = idx_t'(i);
      end
    end
    winner_idx = ptr + off;
    winner     = found ? (req_vec_t'(1) << winner_idx) : '0;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - 8-requester round-robin arbiter with registered one-hot and encoded grant
// Optional tenure limit with preemption is enabled by defining ARB_HOLD_LIMIT_EN.
module rr_arbiter8
  import arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_vld,
  output logic       preempt
);

  arb_state_t state_q, state_d;
  idx_t       ptr_q, ptr_d;
  req_vec_t   gnt_q, gnt_d;
  idx_t       gnt_idx_q, gnt_idx_d;
  logic       gnt_vld_q, gnt_vld_d;
  logic       take;

  req_vec_t   mask;
  logic       found;
  req_vec_t   winner;
  idx_t       winner_idx;

`ifdef ARB_HOLD_LIMIT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       preempt_q, preempt_d;
`endif

  // The current owner never competes when re-arbitrating, so it cannot regrant itself
  assign mask = (state_q == GRANT) ? gnt_q : '0;

  rr_pick8 u_pick (
    .req        (req),
    .mask       (mask),
    .ptr        (ptr_q),
    .found      (found),
    .winner     (winner),
    .winner_idx (winner_idx)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    gnt_idx_d = gnt_idx_q;
    gnt_vld_d = gnt_vld_q;
    take      = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
    hold_cnt_d = hold_cnt_q;
    preempt_d  = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        take = found;
      end
      GRANT: begin
        if (!req[gnt_idx_q]) begin
          if (found) begin
            take = 1'b1;
          end else begin
            state_d   = IDLE;
            gnt_d     = '0;
            gnt_idx_d = '0;
            gnt_vld_d = 1'b0;
          end
        end
`ifdef ARB_HOLD_LIMIT_EN
        else if (hold_cnt_q == HOLD_LAST && found) begin
          take      = 1'b1;
          preempt_d = 1'b1;
        end else if (hold_cnt_q != HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (take) begin
      state_d   = GRANT;
      gnt_d     = winner;
      gnt_idx_d = winner_idx;
      gnt_vld_d = 1'b1;
      ptr_d     = winner_idx + idx_t'(1);
`ifdef ARB_HOLD_LIMIT_EN
      hold_cnt_d = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      gnt_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_vld_q <= gnt_vld_d;
    end
  end

`ifdef ARB_HOLD_LIMIT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_q <= '0;
      preempt_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      preempt_q  <= preempt_d;
    end
  end

  assign preempt = preempt_q;
`else
  assign preempt = 1'b0;
`endif

  assign gnt     = gnt_q;
  assign gnt_idx = gnt_idx_q;
  assign gnt_vld = gnt_vld_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb/tb_rr_arbiter8.sv - randomized and directed checks of rr_arbiter8 against a behavioural model
// Honours ARB_HOLD_LIMIT_EN in the model and in the directed tenure-limit expectations.
module tb_rr_arbiter8;
  import arb_pkg::*;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       preempt;

  int n_checks = 0;
  int n_fail   = 0;
  bit run      = 0;

  typedef struct {
    int owner;
    int ptr;
    int hold;
    bit pre;
  } mdl_t;

  mdl_t m = '{owner: -1, ptr: 0, hold: 0, pre: 0};

  rr_arbiter8 dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .preempt (preempt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // First requester at or after p (mod 8) that is set and is not excl
  function automatic int pick(logic [7:0] r, int excl, int p);
    for (int k = 0; k < 8; k++) begin
      int j;
      j = (p + k) % 8;
      if (j != excl && r[j]) return j;
    end
    return -1;
  endfunction

  function automatic mdl_t step(mdl_t cur, logic [7:0] r);
    mdl_t nx;
    int   w;
    nx     = cur;
    nx.pre = 0;
    if (cur.owner < 0) begin
      w = pick(r, -1, cur.ptr);
    end else if (!r[cur.owner]) begin
      w = pick(r, cur.owner, cur.ptr);
      if (w < 0) begin
        nx.owner = -1;
        nx.hold  = 0;
      end
    end else begin
      w = -1;
`ifdef ARB_HOLD_LIMIT_EN
      if (cur.hold == MAX_HOLD - 1) begin
        w = pick(r, cur.owner, cur.ptr);
        nx.pre = (w >= 0);
      end else begin
        nx.hold = cur.hold + 1;
      end
`endif
    end
    if (w >= 0) begin
      nx.owner = w;
      nx.ptr   = (w + 1) % 8;
      nx.hold  = 0;
    end
    return nx;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '{owner: -1, ptr: 0, hold: 0, pre: 0};
    else     m <= step(m, req);
  end

  always @(negedge clk) begin
    if (run) begin
      chk("gnt", gnt, (m.owner < 0) ? 32'h0 : (32'h1 << m.owner));
      chk("gnt_idx", gnt_idx, (m.owner < 0) ? 32'h0 : m.owner);
      chk("gnt_vld", gnt_vld, (m.owner >= 0));
      chk("preempt", preempt, m.pre);
      chk("onehot", ($countones(gnt) <= 1), 1);
    end
  end

  task automatic set_req(input logic [7:0] r);
    req = r;
    @(negedge clk);
  endtask

  task automatic expect_gnt(input string name, input int idx);
    chk({name, "_gnt"}, gnt, (idx < 0) ? 32'h0 : (32'h1 << idx));
    chk({name, "_idx"}, gnt_idx, (idx < 0) ? 32'h0 : idx);
    chk({name, "_vld"}, gnt_vld, (idx >= 0));
  endtask

  task automatic async_reset_check(input string name);
    #2 rst = 1'b1;
    #1;
    expect_gnt(name, -1);
    chk({name, "_preempt"}, preempt, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] r;
    rst = 1'b1;
    req = 8'h00;
    repeat (2) @(negedge clk);
    expect_gnt("reset", -1);
    chk("reset_preempt", preempt, 0);
    rst = 1'b0;
    run = 1;

    // single requester
    set_req(8'h20); expect_gnt("single", 5);
    set_req(8'h00); expect_gnt("single_drop", -1);

    // ptr is 6 after granting 5
    set_req(8'h41); expect_gnt("fair_first", 6);
    set_req(8'h01); expect_gnt("fair_second", 0);
    set_req(8'h00);

    // park ptr at 0, then rotate through all owners with wrap
    set_req(8'h80); expect_gnt("park", 7);
    set_req(8'h00);
    set_req(8'hFF); expect_gnt("rot_start", 0);
    for (int k = 0; k < 8; k++) begin
      set_req(8'hFF & ~(8'h01 << k)); expect_gnt("rot_switch", (k + 1) % 8);
      set_req(8'hFF);                 expect_gnt("rot_hold", (k + 1) % 8);
    end
    set_req(8'h00);

    // owner 3 releases while 1 waits; then sole requester regranted via IDLE
    set_req(8'h08); expect_gnt("mask_own", 3);
    set_req(8'h0A); expect_gnt("mask_hold", 3);
    set_req(8'h02); expect_gnt("mask_next", 1);
    set_req(8'h0A); expect_gnt("mask_hold1", 1);
    set_req(8'h08); expect_gnt("mask_back", 3);
    set_req(8'h00); expect_gnt("regrant_idle", -1);
    set_req(8'h08); expect_gnt("regrant", 3);
    set_req(8'h00);

    // tenure limit: owner 2 holds while 1 waits
    set_req(8'h04); expect_gnt("hold_own", 2);
    for (int i = 1; i <= MAX_HOLD + 1; i++) begin
      set_req(8'h06);
`ifdef ARB_HOLD_LIMIT_EN
      expect_gnt("hold_pend", (i >= MAX_HOLD) ? 1 : 2);
      chk("hold_preempt", preempt, (i == MAX_HOLD));
`else
      expect_gnt("hold_pend", 2);
      chk("hold_preempt", preempt, 0);
`endif
    end
    set_req(8'h00);
    set_req(8'h04); expect_gnt("hold_alone", 2);
    for (int i = 0; i < MAX_HOLD + 3; i++) begin
      set_req(8'h04);
      expect_gnt("hold_alone_keep", 2);
      chk("hold_alone_preempt", preempt, 0);
    end
    set_req(8'h00);

    // asynchronous reset in the middle of a grant
    set_req(8'h04); expect_gnt("rst_pre", 2);
    async_reset_check("rst_mid");
    set_req(8'h01); expect_gnt("rst_after", 0);

    // randomized traffic, biased toward owners holding their request
    for (int i = 0; i < 3000; i++) begin
      r = 8'($urandom);
      if ($urandom_range(0, 1) == 0) r = r & 8'($urandom);
      if (m.owner >= 0 && $urandom_range(0, 3) != 0) r[m.owner] = 1'b1;
      if (i == 1500) begin
        req = r;
        async_reset_check("rst_rand");
      end else begin
        set_req(r);
      end
    end

    set_req(8'h00);
    set_req(8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one downstream resource among 8 requesters.
- Produces a registered one-hot grant plus its 3-bit encoded index.
- Sits in front of shared datapaths that the 8:3 encode path feeds; it turns multi-hot request vectors into a single, fairly rotated, encoded selection.
- A grant is held until the owner drops its request.

Parameters:
- N, 8, number of requesters; fixed at 8 for this block.
- IDXW, 3, index width, clog2(N).
- MAX_HOLD, 16, maximum grant tenure in cycles. Used only when ARB_HOLD_LIMIT_EN is defined. Legal range 2..255.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  request vector; bit i = requester i wants the resource.
- gnt  output  8  registered one-hot grant; all-zero when idle.
- gnt_idx  output  3  binary index of the set gnt bit; 0 when idle.
- gnt_vld  output  1  high whenever gnt is non-zero.
- preempt  output  1  one-cycle pulse when a grant is forcibly revoked (tied 0 without the macro).

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high. Clock port is clk, reset port is rst.
- Reset values: gnt=0, gnt_idx=0, gnt_vld=0, preempt=0, ptr=0, state=IDLE, hold_cnt=0.
- Reset asserted mid-grant clears all outputs immediately, with no clock edge needed.
- State register has two states, IDLE and GRANT.
- Pointer ptr (3 bits) marks the highest-priority index. Priority order is ptr, ptr+1, ..., ptr+7, all mod 8 (wrap-around 7 -> 0).
- Winner selection:
  - winner = first set bit of the candidate vector, scanning from ptr upward with wrap.
  - Candidate vector is req in IDLE.
  - Candidate vector is req with the current owner masked off when re-arbitrating in GRANT.
- IDLE:
  - req==0: stay IDLE, outputs 0.
  - req!=0: at the next edge, gnt=onehot(winner), gnt_idx=winner, gnt_vld=1, ptr=winner+1, state=GRANT.
  - Latency from req to gnt is 1 cycle.
- GRANT, owner holds request (req[gnt_idx]==1): hold the grant. Other requesters are ignored.
- GRANT, owner releases (req[gnt_idx]==0):
  - If other requests are pending: switch to the new winner at the next edge, back-to-back with no idle cycle. ptr=winner+1.
  - If none are pending: at the next edge, gnt=0, gnt_idx=0, gnt_vld=0, state=IDLE. ptr is unchanged.
- Simultaneous owner release and new request from the same requester: the owner is masked that cycle, so it cannot regrant itself while others wait. If it is the only requester, it is regranted via IDLE one cycle later.
- Outputs change only on clk edges. gnt is never multi-hot. gnt_idx always equals the encoded gnt.

Optional Feature:
- Macro: ARB_HOLD_LIMIT_EN.
- Defined:
  - 8-bit hold_cnt clears on every new grant and increments each cycle in GRANT.
  - When hold_cnt==MAX_HOLD-1, the owner still requests, and another requester is pending: at the next edge the grant moves to the winner among the others. preempt pulses high for exactly that cycle.
  - If no other requester is pending, the owner keeps the grant and hold_cnt saturates at MAX_HOLD-1.
  - Preemption uses the same masked winner path as a normal release.
- Undefined: no counter is instantiated, preempt is tied 0, and grants are held indefinitely.

Decomposition:
- Shared package arb_pkg holds:
  - N, IDXW, MAX_HOLD defaults;
  - the state enum arb_state_t {IDLE, GRANT};
  - typedefs req_vec_t (logic [7:0]) and idx_t (logic [2:0]).
- One combinational sub-module, rr_pick8:
  - inputs: req vector, mask, ptr;
  - outputs: found, winner one-hot[7:0], winner_idx[2:0];
  - implements the rotate, priority-find and 8:3 encode.
- The top level holds the state, ptr, hold counter and output registers.

Test Plan:
- Reset: assert rst mid-grant with gnt=8'h04 -> gnt=0, gnt_idx=0, gnt_vld=0 immediately, before any edge; after release, req=8'h01 grants idx 0.
- Single requester: req=8'h20 -> one cycle later gnt=8'h20, gnt_idx=5, gnt_vld=1; drop req -> next cycle gnt=0.
- Rotation with wrap: req=8'hFF held; each owner drops its req for one cycle in turn -> grants in order 0,1,...,7,0, back-to-back with no idle cycle.
- Fairness: ptr=6 after granting 5; req=8'h41 (bits 0 and 6) -> grant idx 6 first, then 0 after 6 releases.
- Self-mask: owner 3 drops req and reasserts it the same cycle that bit 1 is pending -> next grant is 1, not 3.
- ARB_HOLD_LIMIT_EN, MAX_HOLD=4: owner 2 holds and req=8'h06 -> after 4 grant cycles gnt moves to idx 1 with preempt=1 for one cycle. With req=8'h04 only, no preempt and the grant stays at 2.
